// File: rtl/ship_sprite_sched_pkg.sv
// Shared types and sprite geometry for the ship sprite scheduler.
package ship_pkg;

  localparam int SPRITE_W = 16;
  localparam int SPRITE_H = 16;

  typedef logic [15:0] sprite_row_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

endpackage

// File: rtl/ship_sprite_sched_if.sv
// Line-timing, ship-table, sprite-ROM and pixel-output bundle of the ship sprite scheduler.
interface ship_sprite_sched_if
  import ship_pkg::*;
#(
  parameter int N_SHIPS = 4,
  parameter int COORD_W = 10,
  parameter int ID_W    = 3
);

  logic                       line_start;
  logic [COORD_W-1:0]         next_y;
  logic                       line_go;
  logic [COORD_W-1:0]         hpos;
  logic [N_SHIPS-1:0]         ship_en;
  logic [N_SHIPS*COORD_W-1:0] ship_x;
  logic [N_SHIPS*COORD_W-1:0] ship_y;
  logic [3:0]                 rom_y;
  sprite_row_t                rom_bits;
  logic                       pix_on;
  logic [ID_W-1:0]            pix_id;
  logic                       busy;
  logic                       overrun;

  modport master (
    output line_start, next_y, line_go, hpos, ship_en, ship_x, ship_y, rom_bits,
    input  rom_y, pix_on, pix_id, busy, overrun
  );

  modport slave (
    input  line_start, next_y, line_go, hpos, ship_en, ship_x, ship_y, rom_bits,
    output rom_y, pix_on, pix_id, busy, overrun
  );

endinterface

// File: rtl/ship_sprite_sched_hit_prio.sv
// Pixel-path compare of hpos against every live ship row, lowest slot index wins.
module ship_hit_prio
  import ship_pkg::*;
#(
  parameter int N_SHIPS = 4,
  parameter int COORD_W = 10,
  parameter int ID_W    = 3
) (
  input  logic [COORD_W-1:0]         hpos_i,
  input  logic [N_SHIPS*COORD_W-1:0] ship_x_i,
  input  sprite_row_t [N_SHIPS-1:0]  live_row_i,
  input  logic [N_SHIPS-1:0]         live_v_i,
  output logic                       hit_o,
  output logic [ID_W-1:0]            id_o
);

  logic [COORD_W:0]   dx_s [N_SHIPS];
  logic [N_SHIPS-1:0] slot_hit_s;

  // Signed one-bit-wider dx keeps ships near the right edge from aliasing to small hpos.
  always_comb begin
    for (int i = 0; i < N_SHIPS; i++) begin
      dx_s[i]       = {1'b0, hpos_i} - {1'b0, ship_x_i[i*COORD_W +: COORD_W]};
      slot_hit_s[i] = live_v_i[i] && !dx_s[i][COORD_W] &&
                      (dx_s[i][COORD_W-1:0] < COORD_W'(SPRITE_W)) &&
                      live_row_i[i][4'(SPRITE_W-1) - dx_s[i][3:0]];
    end
  end

  // Walk downward so the lowest hitting index is the last one written.
  always_comb begin
    hit_o = 1'b0;
    id_o  = {ID_W{1'b0}};
    for (int i = N_SHIPS-1; i >= 0; i--) begin
      hit_o = hit_o | slot_hit_s[i];
      id_o  = slot_hit_s[i] ? ID_W'(i) : id_o;
    end
  end

endmodule

// File: rtl/ship_sprite_sched.sv
// Walks the shared ship sprite ROM during hblank into shadow rows, then drives the
// registered per-pixel ship hit/ID from the live rows.
module ship_sprite_sched
  import ship_pkg::*;
#(
  parameter int N_SHIPS = 4,
  parameter int COORD_W = 10,
  parameter int ID_W    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  ship_sprite_sched_if.slave  bus
);

  localparam int                SLOT_W    = (N_SHIPS > 1) ? $clog2(N_SHIPS) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_SHIPS-1);

  state_t                    state_q, state_d;
  logic [SLOT_W-1:0]         slot_q, slot_d;
  logic [COORD_W-1:0]        tgt_y_q, tgt_y_d;
  sprite_row_t [N_SHIPS-1:0] shadow_row_q, shadow_row_d;
  sprite_row_t [N_SHIPS-1:0] live_row_q, live_row_d;
  logic [N_SHIPS-1:0]        shadow_v_q, shadow_v_d;
  logic [N_SHIPS-1:0]        live_v_q, live_v_d;
  logic                      overrun_q, overrun_d;
  logic                      pix_on_q, pix_on_d;
  logic [ID_W-1:0]           pix_id_q, pix_id_d;

  logic                      busy_s;
  logic [COORD_W-1:0]        slot_y_s;
  logic [COORD_W:0]          dy_s;
  logic                      fetch_hit_s;
  logic [3:0]                rom_y_s;
  logic                      prio_hit_s;
  logic [ID_W-1:0]           prio_id_s;

  // Fetch datapath: row offset of the current slot for the target line.
  always_comb begin
    busy_s   = (state_q == FETCH);
    slot_y_s = {COORD_W{1'b0}};
    for (int i = 0; i < N_SHIPS; i++) begin
      slot_y_s = (slot_q == SLOT_W'(i)) ? bus.ship_y[i*COORD_W +: COORD_W] : slot_y_s;
    end
    dy_s        = {1'b0, tgt_y_q} - {1'b0, slot_y_s};
    fetch_hit_s = busy_s && bus.ship_en[slot_q] && !dy_s[COORD_W] &&
                  (dy_s[COORD_W-1:0] < COORD_W'(SPRITE_H));
    rom_y_s     = fetch_hit_s ? dy_s[3:0] : 4'd0;
  end

  // FSM next state; a line_start mid-walk restarts from slot 0.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    tgt_y_d = tgt_y_q;
    case (state_q)
      IDLE: begin
        if (bus.line_start) begin
          state_d = FETCH;
          slot_d  = {SLOT_W{1'b0}};
          tgt_y_d = bus.next_y;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        if (bus.line_start) begin
          slot_d  = {SLOT_W{1'b0}};
          tgt_y_d = bus.next_y;
        end else if (slot_q == LAST_SLOT) begin
          state_d = IDLE;
          slot_d  = {SLOT_W{1'b0}};
        end else begin
          slot_d = slot_q + SLOT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        slot_d  = {SLOT_W{1'b0}};
      end
    endcase
  end

  // Shadow/live row update; line_go copies the pre-edge shadow so a same-cycle fetch start is safe.
  always_comb begin
    shadow_row_d = shadow_row_q;
    shadow_v_d   = shadow_v_q;
    if (busy_s) begin
      shadow_v_d[slot_q]   = fetch_hit_s;
      shadow_row_d[slot_q] = fetch_hit_s ? bus.rom_bits : shadow_row_q[slot_q];
    end else begin
      shadow_v_d = shadow_v_q;
    end
    live_row_d = bus.line_go ? shadow_row_q : live_row_q;
    live_v_d   = bus.line_go ? shadow_v_q : live_v_q;
    overrun_d  = overrun_q | (busy_s & (bus.line_start | bus.line_go));
    pix_on_d   = prio_hit_s;
    pix_id_d   = prio_hit_s ? prio_id_s : {ID_W{1'b0}};
  end

  ship_hit_prio #(
    .N_SHIPS (N_SHIPS),
    .COORD_W (COORD_W),
    .ID_W    (ID_W)
  ) u_hit_prio (
    .hpos_i     (bus.hpos),
    .ship_x_i   (bus.ship_x),
    .live_row_i (live_row_q),
    .live_v_i   (live_v_q),
    .hit_o      (prio_hit_s),
    .id_o       (prio_id_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      slot_q       <= {SLOT_W{1'b0}};
      tgt_y_q      <= {COORD_W{1'b0}};
      shadow_row_q <= {(N_SHIPS*16){1'b0}};
      live_row_q   <= {(N_SHIPS*16){1'b0}};
      shadow_v_q   <= {N_SHIPS{1'b0}};
      live_v_q     <= {N_SHIPS{1'b0}};
      overrun_q    <= 1'b0;
      pix_on_q     <= 1'b0;
      pix_id_q     <= {ID_W{1'b0}};
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      tgt_y_q      <= tgt_y_d;
      shadow_row_q <= shadow_row_d;
      live_row_q   <= live_row_d;
      shadow_v_q   <= shadow_v_d;
      live_v_q     <= live_v_d;
      overrun_q    <= overrun_d;
      pix_on_q     <= pix_on_d;
      pix_id_q     <= pix_id_d;
    end
  end

  assign bus.rom_y   = rom_y_s;
  assign bus.busy    = busy_s;
  assign bus.overrun = overrun_q;
  assign bus.pix_on  = pix_on_q;
  assign bus.pix_id  = pix_id_q;

endmodule

// File: tb/tb_ship_sprite_sched.sv
// Directed plus randomized bench for ship_sprite_sched against a line-level reference model.
module tb_ship_sprite_sched;

  localparam int N  = 4;
  localparam int CW = 10;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ship_sprite_sched_if #(.N_SHIPS(N), .COORD_W(CW), .ID_W(IW)) bus ();

  ship_sprite_sched #(.N_SHIPS(N), .COORD_W(CW), .ID_W(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [15:0] rom_mem [16];
  assign bus.rom_bits = rom_mem[bus.rom_y];

  int          vectors = 0;
  int          miscompares = 0;
  int          sx [N];
  int          sy [N];
  logic [N-1:0] en;
  logic [15:0] sh_row [N];
  logic [15:0] lv_row [N];
  logic        sh_v [N];
  logic        lv_v [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_ships();
    for (int i = 0; i < N; i++) begin
      bus.ship_x[i*CW +: CW] = sx[i][CW-1:0];
      bus.ship_y[i*CW +: CW] = sy[i][CW-1:0];
    end
    bus.ship_en = en;
  endtask

  function automatic int row_of(input int tgt, input int j);
    int dy;
    dy = tgt - sy[j];
    return (en[j] && dy >= 0 && dy < 16) ? dy : -1;
  endfunction

  task automatic model_fetch(input int tgt);
    for (int j = 0; j < N; j++) begin
      if (row_of(tgt, j) >= 0) begin
        sh_v[j]   = 1'b1;
        sh_row[j] = rom_mem[row_of(tgt, j)];
      end else begin
        sh_v[j] = 1'b0;
      end
    end
  endtask

  task automatic model_commit();
    for (int j = 0; j < N; j++) begin
      lv_v[j]   = sh_v[j];
      lv_row[j] = sh_row[j];
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < N; j++) begin
      sh_v[j] = 1'b0; lv_v[j] = 1'b0; sh_row[j] = 16'h0; lv_row[j] = 16'h0;
    end
  endtask

  task automatic exp_pix(input int h, output logic on, output logic [IW-1:0] id);
    int dx;
    on = 1'b0;
    id = '0;
    for (int i = N-1; i >= 0; i--) begin
      dx = h - sx[i];
      if (lv_v[i] && dx >= 0 && dx < 16 && lv_row[i][15-dx]) begin
        on = 1'b1;
        id = i[IW-1:0];
      end
    end
  endtask

  // Walk the slots after the pulse edge, checking busy and the ROM row address of each slot.
  task automatic check_walk(input int tgt);
    int r;
    for (int j = 0; j < N; j++) begin
      r = row_of(tgt, j);
      chk("busy_walk", bus.busy, 1);
      chk("rom_y", bus.rom_y, (r < 0) ? 0 : r);
      @(negedge clk);
    end
    chk("busy_done", bus.busy, 0);
  endtask

  task automatic do_fetch(input int ny);
    bus.next_y = ny[CW-1:0];
    bus.line_start = 1'b1;
    @(negedge clk);
    bus.line_start = 1'b0;
    check_walk(ny);
    model_fetch(ny);
  endtask

  task automatic do_go();
    bus.line_go = 1'b1;
    @(negedge clk);
    bus.line_go = 1'b0;
    model_commit();
  endtask

  task automatic sweep(input int lo, input int hi);
    logic           on;
    logic [IW-1:0]  id;
    bus.hpos = lo[CW-1:0];
    for (int h = lo; h <= hi; h++) begin
      @(negedge clk);
      exp_pix(h, on, id);
      chk("pix_on", bus.pix_on, on);
      chk("pix_id", bus.pix_id, id);
      bus.hpos = CW'(h + 1);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_rom_y"}, bus.rom_y, 0);
    chk({tag, "_pix_on"}, bus.pix_on, 0);
    chk({tag, "_pix_id"}, bus.pix_id, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_overrun"}, bus.overrun, 0);
  endtask

  initial begin
    logic           on;
    logic [IW-1:0]  id;
    int             tgt;
    int             k;
    bus.line_start = 1'b0; bus.line_go = 1'b0; bus.next_y = '0; bus.hpos = '0;
    for (int r = 0; r < 16; r++) rom_mem[r] = 16'($urandom);
    rom_mem[2] = 16'h3FFC;
    for (int i = 0; i < N; i++) begin sx[i] = 600; sy[i] = 500; end
    en = '0;
    apply_ships();
    model_reset();

    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single ship, row 2 of the sprite.
    en = 4'b0001; sx[0] = 200; sy[0] = 100; apply_ships();
    do_fetch(102); do_go(); sweep(190, 220);

    // Target line just above and just below the sprite.
    do_fetch(99);  do_go(); sweep(190, 220);
    do_fetch(116); do_go(); sweep(190, 220);

    // Overlapping ships: lowest enabled index wins.
    en = 4'b0101; sx[0] = 50; sy[0] = 10; sx[2] = 50; sy[2] = 10; apply_ships();
    do_fetch(17); do_go(); sweep(40, 70);
    en = 4'b0100; apply_ships();
    do_fetch(17); do_go(); sweep(40, 70);

    // Ship at the right edge must not wrap to low hpos.
    en = 4'b0001; sx[0] = 1020; sy[0] = 0; apply_ships();
    do_fetch(5); do_go(); sweep(0, 15); sweep(1010, 1023);

    // line_go during a walk flags overrun.
    chk("overrun_pre", bus.overrun, 0);
    bus.next_y = 10'd5; bus.line_start = 1'b1;
    @(negedge clk);
    bus.line_start = 1'b0; bus.line_go = 1'b1;
    @(negedge clk);
    bus.line_go = 1'b0;
    chk("overrun_go", bus.overrun, 1);
    repeat (3) @(negedge clk);
    chk("busy_after_go", bus.busy, 0);
    model_fetch(5);

    // Asynchronous reset in the middle of a walk while a pixel is lit.
    sx[0] = 200; sy[0] = 100; apply_ships();
    do_fetch(102); do_go();
    bus.hpos = 10'd205;
    @(negedge clk);
    exp_pix(205, on, id);
    chk("pix_before_rst", bus.pix_on, on);
    bus.next_y = 10'd102; bus.line_start = 1'b1;
    @(negedge clk);
    bus.line_start = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("idle_after_rst", bus.busy, 0);
      chk("dark_after_rst", bus.pix_on, 0);
    end

    // Restart two cycles into a walk, 40 then 41.
    en = 4'b0011; sx[0] = 300; sy[0] = 30; sx[1] = 310; sy[1] = 41; apply_ships();
    chk("overrun_clr", bus.overrun, 0);
    bus.next_y = 10'd40; bus.line_start = 1'b1;
    @(negedge clk);
    bus.line_start = 1'b0;
    @(negedge clk);
    bus.next_y = 10'd41; bus.line_start = 1'b1;
    @(negedge clk);
    bus.line_start = 1'b0;
    check_walk(41);
    chk("overrun_restart", bus.overrun, 1);
    model_fetch(41);
    do_go(); sweep(295, 330);

    // Simultaneous line_start and line_go: commit sees the pre-walk shadow.
    do_fetch(44);
    bus.next_y = 10'd35; bus.line_start = 1'b1; bus.line_go = 1'b1;
    @(negedge clk);
    bus.line_start = 1'b0; bus.line_go = 1'b0;
    model_commit();
    check_walk(35);
    model_fetch(35);
    sweep(295, 330);
    do_go(); sweep(295, 330);

    // Randomized lines over the full width.
    for (int r = 0; r < 6; r++) begin
      for (int q = 0; q < 16; q++) rom_mem[q] = 16'($urandom);
      tgt = int'($urandom_range(0, 1023));
      en  = N'($urandom);
      for (int i = 0; i < N; i++) begin
        k = int'($urandom_range(0, 20));
        sy[i] = (tgt - k >= 0) ? tgt - k : int'($urandom_range(0, 1023));
        sx[i] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1000, 1023))
                                            : int'($urandom_range(0, 1023));
      end
      apply_ships();
      do_fetch(tgt); do_go(); sweep(0, 1023);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
